rotor: RTL and testbench



---
 rtl/rotor.sv | 113 +++++++++++
 tb/tb_rotor.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rotor.sv
// rotor: three-rotor Enigma position controller.
// Holds left/middle/right rotor positions (0..25) and advances them once per
// rising edge of the rotate request, with notch-driven carries.
// Optional feature macro: ROTOR_DOUBLE_STEP_EN
//   defined   -> authentic middle-rotor double step
//   undefined -> pure odometer stepping
module rotor #(
    parameter int NUM_LETTERS = 26
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rotate,
    input  logic [2:0] rotor_type_2,
    input  logic [2:0] rotor_type_3,
    input  logic [4:0] rotor_start_1,
    input  logic [4:0] rotor_start_2,
    input  logic [4:0] rotor_start_3,
    output logic [4:0] rotor1,
    output logic [4:0] rotor2,
    output logic [4:0] rotor3
);

    localparam logic [4:0] LAST_POS = 5'(NUM_LETTERS - 1);

    logic [4:0] rotor1_q, rotor1_d;
    logic [4:0] rotor2_q, rotor2_d;
    logic [4:0] rotor3_q, rotor3_d;
    logic       rotate_q, rotate_d;
    logic       load_pending_q, load_pending_d;

    logic       step_req;
    logic       n2, n3;
    logic       adv1, adv2;

    // True when a wheel of the given type sits at its turnover letter.
    // Types VI..VIII carry two notches (Z and M).
    function automatic logic at_notch(input logic [2:0] wheel, input logic [4:0] pos);
        logic hit;
        case (wheel)
            3'd0:    hit = (pos == 5'd16);
            3'd1:    hit = (pos == 5'd4);
            3'd2:    hit = (pos == 5'd21);
            3'd3:    hit = (pos == 5'd9);
            3'd4:    hit = (pos == 5'd25);
            default: hit = (pos == 5'd25) || (pos == 5'd12);
        endcase
        return hit;
    endfunction

    // +1 modulo the alphabet size.
    function automatic logic [4:0] advance(input logic [4:0] pos);
        return (pos == LAST_POS) ? 5'd0 : pos + 5'd1;
    endfunction

    // Out-of-range start letters collapse to A.
    function automatic logic [4:0] clamp_start(input logic [4:0] s);
        return (32'(s) >= NUM_LETTERS) ? 5'd0 : s;
    endfunction

    assign step_req = rotate & ~rotate_q;
    assign n2       = at_notch(rotor_type_2, rotor2_q);
    assign n3       = at_notch(rotor_type_3, rotor3_q);

    // Carry decisions from pre-step positions.
`ifdef ROTOR_DOUBLE_STEP_EN
    assign adv2 = n3 | n2;
    assign adv1 = n2;
`else
    assign adv2 = n3;
    assign adv1 = n3 & n2;
`endif

    // Next-state: first cycle after reset loads start positions, otherwise step on request.
    always_comb begin
        rotor1_d       = rotor1_q;
        rotor2_d       = rotor2_q;
        rotor3_d       = rotor3_q;
        rotate_d       = rotate;
        load_pending_d = load_pending_q;
        if (load_pending_q) begin
            rotor1_d       = clamp_start(rotor_start_1);
            rotor2_d       = clamp_start(rotor_start_2);
            rotor3_d       = clamp_start(rotor_start_3);
            load_pending_d = 1'b0;
        end else if (step_req) begin
            rotor3_d = advance(rotor3_q);
            if (adv2) rotor2_d = advance(rotor2_q);
            if (adv1) rotor1_d = advance(rotor1_q);
        end
    end

    // State registers; reset clears positions and re-arms the start load.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rotor1_q       <= 5'd0;
            rotor2_q       <= 5'd0;
            rotor3_q       <= 5'd0;
            rotate_q       <= 1'b0;
            load_pending_q <= 1'b1;
        end else begin
            rotor1_q       <= rotor1_d;
            rotor2_q       <= rotor2_d;
            rotor3_q       <= rotor3_d;
            rotate_q       <= rotate_d;
            load_pending_q <= load_pending_d;
        end
    end

    assign rotor1 = rotor1_q;
    assign rotor2 = rotor2_q;
    assign rotor3 = rotor3_q;

endmodule

// File: tb/tb_rotor.sv
// tb_rotor: scoreboard bench for rotor. Stimulus pushes hand-computed expected
// positions tagged with the cycle they must be visible; a monitor pops and
// compares them on the falling edge.
module tb_rotor;

    logic       clock = 1'b0;
    logic       reset;
    logic       rotate;
    logic [2:0] rotor_type_2, rotor_type_3;
    logic [4:0] rotor_start_1, rotor_start_2, rotor_start_3;
    logic [4:0] rotor1, rotor2, rotor3;

    typedef struct {
        int         stamp;
        logic [4:0] r1;
        logic [4:0] r2;
        logic [4:0] r3;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    rotor #(.NUM_LETTERS(26)) dut (
        .clock        (clock),
        .reset        (reset),
        .rotate       (rotate),
        .rotor_type_2 (rotor_type_2),
        .rotor_type_3 (rotor_type_3),
        .rotor_start_1(rotor_start_1),
        .rotor_start_2(rotor_start_2),
        .rotor_start_3(rotor_start_3),
        .rotor1       (rotor1),
        .rotor2       (rotor2),
        .rotor3       (rotor3)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: compare every expectation due by this cycle.
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].stamp <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (rotor1 !== e.r1 || rotor2 !== e.r2 || rotor3 !== e.r3) begin
                errors++;
                $display("FAIL %s: got %0d,%0d,%0d expected %0d,%0d,%0d",
                         e.name, rotor1, rotor2, rotor3, e.r1, e.r2, e.r3);
            end
        end
    end

    task automatic expect_at(input int dly, input logic [4:0] a, input logic [4:0] b,
                             input logic [4:0] c, input string nm);
        exp_t e;
        e.stamp = cyc + dly;
        e.r1 = a; e.r2 = b; e.r3 = c; e.name = nm;
        sb.push_back(e);
    endtask

    // Advance to 1 time unit after the next n rising edges.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Reset (checked asynchronously), release, then check the loaded starts.
    task automatic do_reset(input logic [2:0] t2, input logic [2:0] t3,
                            input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] s3,
                            input logic [4:0] e1, input logic [4:0] e2, input logic [4:0] e3,
                            input string nm);
        rotor_type_2  = t2;
        rotor_type_3  = t3;
        rotor_start_1 = s1;
        rotor_start_2 = s2;
        rotor_start_3 = s3;
        reset = 1'b0;
        expect_at(0, 5'd0, 5'd0, 5'd0, {nm, "_rst"});
        tick(1);
        reset = 1'b1;
        expect_at(1, e1, e2, e3, {nm, "_load"});
        tick(2);
    endtask

    // One rotate pulse; optionally check the result one cycle later.
    task automatic pulse(input bit chk, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] c, input string nm);
        rotate = 1'b1;
        if (chk) expect_at(1, a, b, c, nm);
        tick(1);
        rotate = 1'b0;
        tick(1);
    endtask

    initial begin
        reset = 1'b0; rotate = 1'b0;
        rotor_type_2 = 3'd1; rotor_type_3 = 3'd2;
        rotor_start_1 = 5'd0; rotor_start_2 = 5'd0; rotor_start_3 = 5'd0;
        tick(1);

        // Reset/load: II/III, AAA, one pulse -> AAB
        do_reset(3'd1, 3'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, "rl");
        pulse(1, 5'd0, 5'd0, 5'd1, "rl_AAB");

        // Carry: middle III, right II; right notch E
        do_reset(3'd2, 3'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, "cy");
        for (int i = 1; i <= 22; i++) begin
            if (i == 4)       pulse(1, 5'd0, 5'd0, 5'd4,  "cy_AAE");
            else if (i == 5)  pulse(1, 5'd0, 5'd1, 5'd5,  "cy_ABF");
            else if (i == 22) pulse(1, 5'd0, 5'd1, 5'd22, "cy_ABW");
            else              pulse(0, 5'd0, 5'd0, 5'd0,  "");
        end

        // Double step: II/III from A,D,U
        do_reset(3'd1, 3'd2, 5'd0, 5'd3, 5'd20, 5'd0, 5'd3, 5'd20, "ds");
        pulse(1, 5'd0, 5'd3, 5'd21, "ds_ADV");
        pulse(1, 5'd0, 5'd4, 5'd22, "ds_AEW");
`ifdef ROTOR_DOUBLE_STEP_EN
        pulse(1, 5'd1, 5'd5, 5'd23, "ds_BFX");
`else
        pulse(1, 5'd0, 5'd4, 5'd23, "ds_AEX");
`endif

        // Middle VIII at M, right not at notch
        do_reset(3'd7, 3'd0, 5'd0, 5'd12, 5'd0, 5'd0, 5'd12, 5'd0, "m8");
`ifdef ROTOR_DOUBLE_STEP_EN
        pulse(1, 5'd1, 5'd13, 5'd1, "m8_BNB");
`else
        pulse(1, 5'd0, 5'd12, 5'd1, "m8_AMB");
`endif

        // Wrap: ZZZ with V/V -> AAA
        do_reset(3'd4, 3'd4, 5'd25, 5'd25, 5'd25, 5'd25, 5'd25, 5'd25, "wr");
        pulse(1, 5'd0, 5'd0, 5'd0, "wr_AAA");

        // Dual notch right VI: from L, then from Y
        do_reset(3'd0, 3'd5, 5'd0, 5'd0, 5'd11, 5'd0, 5'd0, 5'd11, "dn");
        pulse(1, 5'd0, 5'd0, 5'd12, "dn_AAM");
        pulse(1, 5'd0, 5'd1, 5'd13, "dn_ABN");
        do_reset(3'd0, 3'd5, 5'd0, 5'd0, 5'd24, 5'd0, 5'd0, 5'd24, "dz");
        pulse(1, 5'd0, 5'd0, 5'd25, "dz_AAZ");
        pulse(1, 5'd0, 5'd1, 5'd0,  "dz_ABA");

        // Out-of-range starts load as A
        do_reset(3'd1, 3'd2, 5'd26, 5'd31, 5'd7, 5'd0, 5'd0, 5'd7, "oor");

        // Held rotate: five cycles high -> one step
        do_reset(3'd1, 3'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, "hd");
        rotate = 1'b1;
        expect_at(1, 5'd0, 5'd0, 5'd1, "hd_step");
        expect_at(5, 5'd0, 5'd0, 5'd1, "hd_hold");
        tick(5);
        rotate = 1'b0;
        tick(1);
        pulse(1, 5'd0, 5'd0, 5'd2, "hd_AAC");

        // Reset mid-sequence, reload new starts
        do_reset(3'd1, 3'd2, 5'd2, 5'd3, 5'd4, 5'd2, 5'd3, 5'd4, "mid");
        pulse(1, 5'd2, 5'd3, 5'd5, "mid_CDF");

        // Rotate high across the load cycle: load wins, no step afterwards
        rotor_start_1 = 5'd1; rotor_start_2 = 5'd1; rotor_start_3 = 5'd1;
        reset = 1'b0;
        rotate = 1'b1;
        tick(1);
        reset = 1'b1;
        expect_at(1, 5'd1, 5'd1, 5'd1, "ldr_load");
        expect_at(3, 5'd1, 5'd1, 5'd1, "ldr_hold");
        tick(4);
        rotate = 1'b0;
        tick(1);

        // Drain with a bounded wait
        for (int i = 0; i < 20 && sb.size() > 0; i++) tick(1);
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
            errors += sb.size();
            checks += sb.size();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
